// File: rtl/out_capture_buffer_pkg.sv
// Shared types and default sizing for the output capture buffer.
package out_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } captureState_t;

    localparam int unsigned DEFAULT_WIDTH        = 36;
    localparam int unsigned DEFAULT_DEPTH        = 16;
    localparam int unsigned DEFAULT_ADDRESSWIDTH = 4;
    localparam int unsigned DEFAULT_LIMIT        = 667;
    localparam int unsigned DEFAULT_COUNTWIDTH   = 16;

endpackage

// File: rtl/capture_fifo.sv
// First-word fall-through FIFO with a drop-new or overwrite-oldest full policy
// and a sticky loss flag; the head word is kept in a register.
module capture_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned ADDRESSWIDTH = $clog2(DEPTH);
    localparam int unsigned LEVELWIDTH   = ADDRESSWIDTH + 1;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [ADDRESSWIDTH-1:0] rdPtr, wrPtr, nextRd, nextWr;
    logic [LEVELWIDTH-1:0]   nextLevel;
    logic [WIDTH-1:0]        headData;
    logic                    popEn, full, writeEn, lossEvent;

    // Occupancy/pointer update; a pop needs a non-empty buffer at the edge.
    always_comb begin
        popEn     = pop && (level != '0);
        full      = (level == LEVELWIDTH'(DEPTH));
        writeEn   = 1'b0;
        lossEvent = 1'b0;
        nextRd    = rdPtr;
        nextWr    = wrPtr;
        nextLevel = level;
        if (push) begin
            if (popEn || !full || overwrite) begin
                writeEn = 1'b1;
                nextWr  = wrPtr + ADDRESSWIDTH'(1);
            end
            if (popEn || (full && overwrite)) begin
                nextRd = rdPtr + ADDRESSWIDTH'(1);
            end
            if (!popEn && !full) begin
                nextLevel = level + LEVELWIDTH'(1);
            end
            if (!popEn && full) begin
                lossEvent = 1'b1;
            end
        end else if (popEn) begin
            nextRd    = rdPtr + ADDRESSWIDTH'(1);
            nextLevel = level - LEVELWIDTH'(1);
        end
        // Bypass the incoming word when it lands exactly at the new head.
        headData = (writeEn && (wrPtr == nextRd)) ? wrData : mem[nextRd];
    end

    always_ff @(posedge clock) begin
        if (writeEn) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Head register holds its value while empty, so it reads 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            level    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            rdData   <= '0;
        end else if (clear) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            level    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rdPtr    <= nextRd;
            wrPtr    <= nextWr;
            level    <= nextLevel;
            valid    <= (nextLevel != '0);
            overflow <= overflow | lossEvent;
            if (nextLevel != '0) begin
                rdData <= headData;
            end
        end
    end

endmodule

// File: rtl/out_capture_buffer.sv
// Captures CPU output words into a FIFO for a bounded run of LIMIT samples,
// with run control FSM and a saturating sample counter.
module out_capture_buffer
    import out_capture_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH,
    parameter int unsigned LIMIT        = DEFAULT_LIMIT,
    parameter int unsigned COUNTWIDTH   = DEFAULT_COUNTWIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    outFlag,
    input  logic [WIDTH-1:0]        out,
    input  logic                    mode,
    output logic [WIDTH-1:0]        dataOut,
    output logic                    dataValid,
    input  logic                    dataReady,
    output logic [COUNTWIDTH-1:0]   captured,
    output logic [ADDRESSWIDTH:0]   level,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int unsigned CW1 = COUNTWIDTH + 1;

    captureState_t    state;
    logic             accept;
    logic             limitHit;
    logic [CW1-1:0]   countPlusOne;

    // A start cycle restarts the run and swallows any coincident outFlag.
    assign accept       = (state == CAPTURE) && outFlag && !start;
    assign countPlusOne = {1'b0, captured} + CW1'(1);
    assign limitHit     = (countPlusOne == CW1'(LIMIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            captured <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            state    <= CAPTURE;
            captured <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (accept) begin
            captured <= (captured == '1) ? captured : captured + COUNTWIDTH'(1);
            if (limitHit) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

    capture_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (start),
        .push      (accept),
        .pop       (dataReady),
        .overwrite (mode),
        .wrData    (out),
        .rdData    (dataOut),
        .valid     (dataValid),
        .level     (level),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_out_capture_buffer.sv
// Directed bench for out_capture_buffer: vector table plus drop/overwrite/limit sequences.
module tb_out_capture_buffer;

    localparam int unsigned WIDTH = 36;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 16;

    logic             clock = 1'b0;
    logic             reset, start, outFlag, mode, dataReady;
    logic [WIDTH-1:0] out;

    logic [WIDTH-1:0] dataOutA, dataOutB;
    logic             dataValidA, dataValidB, busyA, busyB, doneA, doneB, overflowA, overflowB;
    logic [CW-1:0]    capturedA, capturedB;
    logic [AW:0]      levelA, levelB;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    out_capture_buffer dutA (
        .clock(clock), .reset(reset), .start(start), .outFlag(outFlag), .out(out),
        .mode(mode), .dataOut(dataOutA), .dataValid(dataValidA), .dataReady(dataReady),
        .captured(capturedA), .level(levelA), .busy(busyA), .done(doneA),
        .overflow(overflowA)
    );

    out_capture_buffer #(.LIMIT(4)) dutB (
        .clock(clock), .reset(reset), .start(start), .outFlag(outFlag), .out(out),
        .mode(mode), .dataOut(dataOutB), .dataValid(dataValidB), .dataReady(dataReady),
        .captured(capturedB), .level(levelB), .busy(busyB), .done(doneB),
        .overflow(overflowB)
    );

    typedef struct {
        logic        rst, st, flag;
        logic [7:0]  val;
        logic        md, rdy;
        logic [4:0]  lvl;
        logic [15:0] cap;
        logic        vld;
        logic [7:0]  dout;
        logic        chkD;
        logic        ovf, bsy, dn;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pushWord(input int v);
        outFlag = 1'b1;
        out     = WIDTH'(v);
        step();
        outFlag = 1'b0;
    endtask

    task automatic drain(input string name, input int first, input int count);
        dataReady = 1'b1;
        for (int i = 0; i < count; i++) begin
            check(name, 64'(dataOutA), 64'(first + i));
            step();
        end
        dataReady = 1'b0;
        check({name, "_empty"}, 64'(dataValidA), 64'd0);
        check({name, "_lvl0"}, 64'(levelA), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; outFlag = 1'b0; mode = 1'b0; dataReady = 1'b0; out = '0;

        //            rst st fl val md rdy | lvl cap vld dout chkD ovf bsy dn
        vecs[0]  = '{1, 0, 0, 0,  0, 0,   0, 0, 0, 0,  1, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0,  0, 0,   0, 0, 0, 0,  1, 0, 1, 0};
        vecs[2]  = '{0, 0, 1, 5,  0, 0,   1, 1, 1, 5,  1, 0, 1, 0};
        vecs[3]  = '{0, 0, 1, 6,  0, 0,   2, 2, 1, 5,  1, 0, 1, 0};
        vecs[4]  = '{0, 0, 1, 7,  0, 0,   3, 3, 1, 5,  1, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 0,  0, 1,   2, 3, 1, 6,  1, 0, 1, 0};
        vecs[6]  = '{0, 0, 1, 8,  0, 1,   2, 4, 1, 7,  1, 0, 1, 0};
        vecs[7]  = '{0, 1, 1, 9,  0, 0,   0, 0, 0, 0,  0, 0, 1, 0};
        vecs[8]  = '{0, 0, 1, 10, 0, 1,   1, 1, 1, 10, 1, 0, 1, 0};
        vecs[9]  = '{1, 1, 1, 11, 0, 1,   0, 0, 0, 0,  1, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 3,  0, 0,   0, 0, 0, 0,  1, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 0,  0, 0,   0, 0, 0, 0,  1, 0, 1, 0};

        for (int i = 0; i < 12; i++) begin
            reset     = vecs[i].rst;
            start     = vecs[i].st;
            outFlag   = vecs[i].flag;
            out       = WIDTH'(vecs[i].val);
            mode      = vecs[i].md;
            dataReady = vecs[i].rdy;
            step();
            check($sformatf("v%0d_level", i), 64'(levelA), 64'(vecs[i].lvl));
            check($sformatf("v%0d_captured", i), 64'(capturedA), 64'(vecs[i].cap));
            check($sformatf("v%0d_valid", i), 64'(dataValidA), 64'(vecs[i].vld));
            if (vecs[i].chkD) check($sformatf("v%0d_dataOut", i), 64'(dataOutA), 64'(vecs[i].dout));
            check($sformatf("v%0d_overflow", i), 64'(overflowA), 64'(vecs[i].ovf));
            check($sformatf("v%0d_busy", i), 64'(busyA), 64'(vecs[i].bsy));
            check($sformatf("v%0d_done", i), 64'(doneA), 64'(vecs[i].dn));
        end
        reset = 1'b0; start = 1'b0; outFlag = 1'b0; dataReady = 1'b0;

        // Drop-new policy: 17 pushes into 16 entries.
        mode = 1'b0;
        for (int v = 1; v <= 17; v++) begin
            pushWord(v);
            if (v == 16) begin
                check("drop_full_lvl", 64'(levelA), 64'd16);
                check("drop_full_noovf", 64'(overflowA), 64'd0);
            end
        end
        check("drop_lvl", 64'(levelA), 64'd16);
        check("drop_ovf", 64'(overflowA), 64'd1);
        check("drop_cap", 64'(capturedA), 64'd17);
        drain("drop_seq", 1, 16);

        // Overwrite-oldest policy: 18 pushes keep 3..18.
        start = 1'b1; step(); start = 1'b0;
        check("ovw_start_ovf_clr", 64'(overflowA), 64'd0);
        mode = 1'b1;
        for (int v = 1; v <= 18; v++) pushWord(v);
        check("ovw_lvl", 64'(levelA), 64'd16);
        check("ovw_ovf", 64'(overflowA), 64'd1);
        check("ovw_cap", 64'(capturedA), 64'd18);
        drain("ovw_seq", 3, 16);

        // Simultaneous push and pop on a full buffer.
        start = 1'b1; step(); start = 1'b0;
        mode = 1'b0;
        for (int v = 1; v <= 16; v++) pushWord(v);
        dataReady = 1'b1;
        pushWord(17);
        dataReady = 1'b0;
        check("pp_lvl", 64'(levelA), 64'd16);
        check("pp_ovf", 64'(overflowA), 64'd0);
        check("pp_head", 64'(dataOutA), 64'd2);
        drain("pp_seq", 2, 16);

        // Run limit on the LIMIT=4 instance.
        reset = 1'b1; step(); reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            pushWord(v);
            if (v == 3) check("lim_done_early", 64'(doneB), 64'd0);
        end
        check("lim_done", 64'(doneB), 64'd1);
        check("lim_busy", 64'(busyB), 64'd0);
        check("lim_cap", 64'(capturedB), 64'd4);
        pushWord(5);
        check("lim_ignore_cap", 64'(capturedB), 64'd4);
        check("lim_ignore_lvl", 64'(levelB), 64'd4);
        dataReady = 1'b1; step(); dataReady = 1'b0;
        check("lim_drain_lvl", 64'(levelB), 64'd3);
        check("lim_drain_head", 64'(dataOutB), 64'd2);
        check("lim_drain_done", 64'(doneB), 64'd1);

        // Reset with data buffered discards it.
        reset = 1'b1; dataReady = 1'b1; outFlag = 1'b1; step();
        reset = 1'b0; dataReady = 1'b0; outFlag = 1'b0;
        check("rst_lvl", 64'(levelB), 64'd0);
        check("rst_valid", 64'(dataValidB), 64'd0);
        check("rst_dout", 64'(dataOutB), 64'd0);
        check("rst_done", 64'(doneB), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/out_capture_buffer.md
OUT_CAPTURE_BUFFER -- requirements
Module: out_capture_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 36: captured word width.
REQ-002 The block SHALL have parameter DEPTH, default 16: buffer entries, a power of two.
REQ-003 The block SHALL have parameter ADDRESSWIDTH, default 4: log2(DEPTH).
REQ-004 The block SHALL have parameter LIMIT, default 667: samples per capture run.
REQ-005 The block SHALL have parameter COUNTWIDTH, default 16: width of the sample counter.
REQ-006 The block SHALL have port clock, input, 1: the single clock, with all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1: begin or restart a capture run.
REQ-009 The block SHALL have port outFlag, input, 1: CPU output-valid strobe.
REQ-010 The block SHALL have port out, input, WIDTH: CPU output word.
REQ-011 The block SHALL have port mode, input, 1: full-buffer policy (0 = drop new, 1 = overwrite oldest).
REQ-012 The block SHALL have port dataOut, output, WIDTH: oldest buffered word.
REQ-013 The block SHALL have port dataValid, output, 1: buffer non-empty.
REQ-014 The block SHALL have port dataReady, input, 1: consumer pops the word on dataOut.
REQ-015 The block SHALL have port captured, output, COUNTWIDTH: samples seen in the current run.
REQ-016 The block SHALL have port level, output, ADDRESSWIDTH+1: buffer occupancy.
REQ-017 The block SHALL have ports busy, done and overflow, output, 1 each: busy = state is CAPTURE, done = state is DONE, overflow = sticky loss flag.

Function
REQ-018 The FSM SHALL have states IDLE, CAPTURE and DONE.
REQ-019 In IDLE or DONE, start=1 SHALL enter CAPTURE next cycle and clear captured, level, both pointers and overflow.
REQ-020 In CAPTURE, start=1 SHALL restart the run with the REQ-019 clears, and outFlag on that cycle SHALL be ignored.
REQ-021 In CAPTURE, each cycle with outFlag=1 SHALL increment captured and push out.
REQ-022 When the push making captured equal LIMIT occurs, the FSM SHALL enter DONE next cycle.
REQ-023 outFlag SHALL be ignored in IDLE and DONE.
REQ-024 A pushed word SHALL appear on dataOut with dataValid=1 one cycle after capture when the buffer was empty (first-word fall-through).
REQ-025 dataValid SHALL equal (level != 0), and a pop SHALL occur only when dataValid and dataReady are both 1.
REQ-026 A push to a full buffer without a pop SHALL, for mode=0, drop the word, leave level=DEPTH and set overflow.
REQ-027 A push to a full buffer without a pop SHALL, for mode=1, write the word, advance the read pointer, leave level=DEPTH and set overflow.
REQ-028 A simultaneous push and pop SHALL leave level unchanged and SHALL NOT set overflow, including when the buffer is full.
REQ-029 A push and dataReady on an empty buffer SHALL NOT pop, and level SHALL become 1.
REQ-030 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-031 captured SHALL count every accepted outFlag, including dropped samples, and SHALL saturate at all-ones.
REQ-032 Draining SHALL operate in every state, and buffer contents SHALL be retained in DONE.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL enter IDLE and zero captured, level, pointers, overflow, busy, done and dataValid.
REQ-034 reset SHALL have priority over start, outFlag and dataReady.
REQ-035 dataOut SHALL be 0 after reset until the first push.
REQ-036 Reset asserted mid-run SHALL discard all buffered data.

Structure
REQ-037 Package out_capture_pkg SHALL hold the state enum (IDLE, CAPTURE, DONE) and the default WIDTH, DEPTH and LIMIT constants.
REQ-038 The storage SHALL be one sub-module, capture_fifo, with parameters WIDTH and DEPTH and an overwrite input driven by mode.
REQ-039 The FSM and counter SHALL live in out_capture_buffer.

Verification
REQ-040 Run: reset, start, then 3 outFlag pulses with out=5,6,7 and dataReady=0 -> level=3, captured=3, dataOut=5, overflow=0.
REQ-041 Drop: mode=0, 17 pushes of values 1..17 with dataReady=0 -> level=16, overflow=1, drained sequence is 1..16.
REQ-042 Overwrite: mode=1, 18 pushes of values 1..18 -> level=16, overflow=1, drained sequence is 3..18.
REQ-043 Full push+pop and limit: full buffer with push and pop in the same cycle -> level=16, overflow=0; with LIMIT=4, 4 pushes -> done=1 next cycle and a 5th outFlag is ignored.
REQ-044 Reset and restart: start in mid-run with outFlag=1 -> captured=0, level=0 and the sample is ignored; reset asserted together with start -> IDLE, all outputs 0.
